// File: rtl/axi_stream_pack2.sv
// Packs two consecutive DATA_WD AXI-stream beats into one 2*DATA_WD word, earlier beat in the upper half.
// Optional packet-end handling (s_last/m_last/m_keep, odd-beat padding) is enabled by defining AXIS_PACK_LAST_EN.
module axi_stream_pack2 #(
  parameter int unsigned DATA_WD = 4
`ifdef AXIS_PACK_LAST_EN
  ,
  parameter logic [DATA_WD-1:0] PAD_VALUE = '0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_WD-1:0]   s_data,
  output logic                 s_ready,
`ifdef AXIS_PACK_LAST_EN
  input  logic                 s_last,
  output logic                 m_last,
  output logic [1:0]           m_keep,
`endif
  output logic                 m_valid,
  output logic [2*DATA_WD-1:0] m_data,
  input  logic                 m_ready
);

  localparam int unsigned OUT_WD = 2 * DATA_WD;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_WD-1:0]  half_data_q, half_data_d;
  logic                m_valid_q, m_valid_d;
  logic [OUT_WD-1:0]   m_data_q, m_data_d;
`ifdef AXIS_PACK_LAST_EN
  logic                m_last_q, m_last_d;
  logic [1:0]          m_keep_q, m_keep_d;
`endif

  logic out_free;
  logic s_ready_c;
  logic s_fire;

  // Handshake qualifiers; s_ready never looks at s_valid.
  always_comb begin
    out_free  = !m_valid_q || m_ready;
    s_ready_c = 1'b1;
    if (state_q == ST_HALF) begin
      s_ready_c = out_free;
    end
`ifdef AXIS_PACK_LAST_EN
    // A lone last beat is emitted straight away, so it needs the output slot.
    else if (s_last) begin
      s_ready_c = out_free;
    end
`endif
    s_fire = s_valid && s_ready_c;
  end

  assign s_ready = s_ready_c;

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    half_data_d = half_data_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
`ifdef AXIS_PACK_LAST_EN
    m_last_d    = m_last_q;
    m_keep_d    = m_keep_q;
`endif

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (s_fire) begin
      unique case (state_q)
        ST_EMPTY: begin
`ifdef AXIS_PACK_LAST_EN
          if (s_last) begin
            m_valid_d = 1'b1;
            m_data_d  = {s_data, PAD_VALUE};
            m_last_d  = 1'b1;
            m_keep_d  = 2'b10;
          end else begin
            half_data_d = s_data;
            state_d     = ST_HALF;
          end
`else
          half_data_d = s_data;
          state_d     = ST_HALF;
`endif
        end
        ST_HALF: begin
          // Output slot is free here: s_ready already required out_free.
          m_valid_d = 1'b1;
          m_data_d  = {half_data_q, s_data};
          state_d   = ST_EMPTY;
`ifdef AXIS_PACK_LAST_EN
          m_last_d  = s_last;
          m_keep_d  = 2'b11;
`endif
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      half_data_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
`ifdef AXIS_PACK_LAST_EN
      m_last_q    <= 1'b0;
      m_keep_q    <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      half_data_q <= half_data_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
`ifdef AXIS_PACK_LAST_EN
      m_last_q    <= m_last_d;
      m_keep_q    <= m_keep_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
`ifdef AXIS_PACK_LAST_EN
  assign m_last  = m_last_q;
  assign m_keep  = m_keep_q;
`endif

endmodule

// File: tb/tb_axi_stream_pack2.sv
// Scoreboard bench for axi_stream_pack2: directed and random beats, checked against a beat-pairing model.
module tb_axi_stream_pack2;

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] PAD = 4'hF;
`ifdef AXIS_PACK_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          s_last;
  logic          m_valid;
  logic [2*DW-1:0] m_data;
  logic          m_ready;
`ifdef AXIS_PACK_LAST_EN
  logic          m_last;
  logic [1:0]    m_keep;
`endif

  always #5 clk = ~clk;

`ifdef AXIS_PACK_LAST_EN
  axi_stream_pack2 #(.DATA_WD(DW), .PAD_VALUE(PAD)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .s_last(s_last), .m_last(m_last), .m_keep(m_keep),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );
`else
  axi_stream_pack2 #(.DATA_WD(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );
`endif

  typedef struct packed {
    logic [2*DW-1:0] data;
    logic [1:0]      keep;
    logic            last;
  } word_t;

  word_t         exp_q[$];
  logic          pend_vld;
  logic [DW-1:0] pend_data;
  logic          prev_stall;
  logic [2*DW-1:0] prev_data;
  int            checks = 0;
  int            errors = 0;
  int            words_seen = 0;
  int            rdy_mode = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference model: beats are paired in arrival order; a lone last beat is padded.
  always @(negedge clk) begin : monitor
    word_t w;
    if (rst) begin
      exp_q.delete();
      pend_vld   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", m_data);
        end else begin
          w = exp_q.pop_front();
          words_seen++;
          if (m_data !== w.data) begin
            errors++;
            $display("FAIL word_data actual=%0h required=%0h", m_data, w.data);
          end
`ifdef AXIS_PACK_LAST_EN
          chk("word_keep", 32'(m_keep), 32'(w.keep));
          chk("word_last", 32'(m_last), 32'(w.last));
`endif
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_valid && s_ready) begin
        if (!pend_vld && LAST_EN && s_last) begin
          w.data = {s_data, PAD}; w.keep = 2'b10; w.last = 1'b1;
          exp_q.push_back(w);
        end else if (!pend_vld) begin
          pend_vld  = 1'b1;
          pend_data = s_data;
        end else begin
          w.data = {pend_data, s_data}; w.keep = 2'b11; w.last = LAST_EN && s_last;
          exp_q.push_back(w);
          pend_vld = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) m_ready = ~m_ready;
  end

  task automatic send(input logic [DW-1:0] d, input logic last, output int stalls);
    logic ok;
    ok      = 1'b0;
    stalls  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted data=%0h", d);
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int tot;
    int base;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef AXIS_PACK_LAST_EN
    chk("rst_m_keep", 32'(m_keep), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
`endif

    // Back-to-back beats with a free output never stall.
    @(posedge clk); #1;
    m_ready = 1'b1;
    tot = 0;
    send(4'hA, 1'b0, st); tot += st;
    send(4'hB, 1'b0, st); tot += st;
    send(4'hC, 1'b0, st); tot += st;
    send(4'hD, 1'b0, st); tot += st;
    idle();
    chk("t1_stalls", 32'(tot), 32'd0);
    wait_drain("t1_drain");

    // Stalled output with a held half beat blocks input.
    @(posedge clk); #1;
    m_ready = 1'b0;
    tot = 0;
    send(4'h1, 1'b0, st); tot += st;
    send(4'h2, 1'b0, st); tot += st;
    send(4'h3, 1'b0, st); tot += st;
    chk("t2_fill_stalls", 32'(tot), 32'd0);
    s_valid = 1'b1; s_data = 4'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_s_ready_low", 32'(s_ready), 32'd0);
      chk("t2_m_data_held", 32'(m_data), 32'h12);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(4'h4, 1'b0, st);
    chk("t2_release_stalls", 32'(st), 32'd0);
    idle();
    wait_drain("t2_drain");

    // Toggling m_ready with random beats.
    @(posedge clk); #1;
    base = words_seen;
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) send(DW'($urandom), 1'b0, st);
    idle();
    @(posedge clk); #1;
    rdy_mode = 0;
    m_ready  = 1'b1;
    wait_drain("t3_drain");
    chk("t3_word_count", 32'(words_seen - base), 32'd8);

    // Reset drops a held half beat and a pending word.
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(4'h1, 1'b0, st);
    send(4'h2, 1'b0, st);
    send(4'h7, 1'b0, st);
    idle();
    @(negedge clk);
    chk("t4_pre_m_valid", 32'(m_valid), 32'd1);
    chk("t4_pre_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t4_rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(4'h8, 1'b0, st);
    send(4'h9, 1'b0, st);
    idle();
    @(negedge clk);
    chk("t4_latency_valid", 32'(m_valid), 32'd1);
    chk("t4_latency_data", 32'(m_data), 32'h89);
    wait_drain("t4_drain");

`ifdef AXIS_PACK_LAST_EN
    // Odd packet end padded, even packet end flagged.
    @(posedge clk); #1;
    send(4'h5, 1'b1, st);
    idle();
    @(negedge clk);
    chk("t5_pad_data", 32'(m_data), 32'h5F);
    chk("t5_pad_keep", 32'(m_keep), 32'h2);
    chk("t5_pad_last", 32'(m_last), 32'd1);
    @(posedge clk); #1;
    send(4'h6, 1'b0, st);
    send(4'h7, 1'b1, st);
    idle();
    @(negedge clk);
    chk("t5_full_data", 32'(m_data), 32'h67);
    chk("t5_full_keep", 32'(m_keep), 32'h3);
    chk("t5_full_last", 32'(m_last), 32'd1);
    wait_drain("t5_drain");

    // Lone last beat waits for the output slot.
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(4'h1, 1'b0, st);
    send(4'h2, 1'b0, st);
    s_valid = 1'b1; s_data = 4'h3; s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_s_ready_low", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(4'h3, 1'b1, st);
    chk("t6_release_stalls", 32'(st), 32'd0);
    idle();
    @(negedge clk);
    chk("t6_pad_data", 32'(m_data), 32'h3F);
    chk("t6_pad_keep", 32'(m_keep), 32'h2);
    wait_drain("t6_drain");
`endif

    repeat (3) @(negedge clk);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
